adc0804_rr_sched: RTL and testbench
===================================

Name: adc0804_rr_sched

Overview:
- Conversion scheduler for the ADC0804-style 8-bit converter, which has active-low CS/WR/RD strobes, an INTR handshake and an 8-bit data bus.
- Shares the single converter between N_REQ requesters (for example the LED-matrix level display and a threshold monitor) using round-robin arbitration.
- Sequences each start / wait-for-INTR / read cycle, enforces strobe widths, and returns each sample tagged with the requester's ID.
- Replaces ad-hoc per-consumer ADC state machines with one owner of the converter pins.

Parameters:
- N_REQ, 2: number of requesters; legal range 2..8.
- WR_CYC, 4: clk cycles that wr_n is held low in START.
- RD_CYC, 4: clk cycles that rd_n is held low in READ; adata is sampled on the last of these cycles.
- TIMEOUT, 10000: maximum clk cycles spent in WAIT before the conversion is abandoned.
- IDLE_GAP, 10: clk cycles with all strobes high between conversions.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  level conversion request, one bit per requester; held high until done for that requester.
- gnt  out  N_REQ  one-hot grant; high from START entry until GAP entry.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  1-cycle pulse when a result, or a timeout, is delivered.
- dout  out  8  last sampled conversion value.
- dout_id  out  clog2(N_REQ)  index of the requester that owns the current done.
- timeout_err  out  1  1-cycle pulse coincident with done when the conversion timed out.
- cs_n  out  1  ADC chip select, active low, registered.
- wr_n  out  1  ADC start strobe, active low, registered.
- rd_n  out  1  ADC read strobe, active low, registered.
- intr_n  in  1  ADC conversion-complete signal, asynchronous, active low.
- adata  in  8  ADC data bus.

Behaviour:
- Reset values (asynchronous rst):
  - cs_n = wr_n = rd_n = 1.
  - gnt = 0, busy = 0, done = 0, timeout_err = 0.
  - dout = 0, dout_id = 0, state = IDLE.
  - Round-robin pointer last = N_REQ-1, so requester 0 has priority first.
  - Synchronizer flops reset to 1.
- intr_n passes through a 2-flop synchronizer to give intr_s. adata is sampled directly; it is stable while rd_n is low.
- State IDLE:
  - If req is nonzero at a clk edge, the next cycle is START.
  - On that same edge gnt = one-hot winner, cs_n = 0, wr_n = 0.
  - Winner = first set req bit, searching upward from last+1 with wrap-around.
- State START: stays WR_CYC cycles. On exit, cs_n = 1 and wr_n = 1, and the state moves to WAIT.
- State WAIT:
  - On entry, the armed flag and the timeout counter are both cleared.
  - armed sets on the first cycle that intr_s = 1. This rejects a stale low left over from the previous conversion.
  - If armed and intr_s = 0, go to READ: cs_n = 0 and rd_n = 0 from the next cycle.
  - If the counter reaches TIMEOUT-1 first, go to GAP with done = 1, timeout_err = 1 and dout unchanged.
- State READ:
  - Stays RD_CYC cycles.
  - On the edge ending the last READ cycle: dout <= adata, done = 1, cs_n = 1, rd_n = 1, state moves to GAP.
- done and dout_id: dout_id = the grantee index and is valid while done = 1. last is updated to the grantee on both the success and the timeout exit.
- gnt is cleared on GAP entry, in the same cycle as the done pulse.
- State GAP: IDLE_GAP cycles with all strobes high, then IDLE. req is not sampled during GAP.
- Latency:
  - From req seen in IDLE, the first cycle with wr_n low is 1 cycle later.
  - From the first cycle of the INTR low level, READ begins 3 or 4 cycles later (2 synchronizer flops, plus 1 registration cycle, plus 1 extra cycle if armed sets late).
- Boundary conditions:
  - A requester that drops req mid-conversion does not abort the conversion; done is still issued with its ID.
  - All req bits high: strict rotation 0,1,…,N_REQ-1,0.
  - A single requester is served back-to-back, separated by IDLE_GAP + 1 cycles.
  - rst asserted mid-operation returns everything to reset values immediately, with strobes high. No done is issued for the aborted conversion.
  - No more than one bit of gnt is ever high. Assert this in the bench.
  - WAIT counter width is clog2(TIMEOUT+1). START/READ/GAP share one counter of width clog2(max(WR_CYC, RD_CYC, IDLE_GAP)+1).

Decomposition:
- Package adc_sched_pkg:
  - State enum {IDLE, START, WAIT, READ, GAP}, 3-bit.
  - Default parameter constants.
  - Helper function for ID width.
- Sub-module rr_arbiter (parameter N):
  - Inputs req[N], last, en. Output one-hot gnt and the winner index.
  - Combinational search.
  - The pointer register stays in the parent, which updates last on GAP entry.

Test Plan (bench parameters WR_CYC=4, RD_CYC=4, IDLE_GAP=10, TIMEOUT=64; ADC model pulls intr_n low 20 cycles after wr_n rises and drives adata = 8'hA5):
- Single conversion: req = 01 → wr_n low for exactly 4 cycles, rd_n low for 4 cycles, done pulse with dout = A5 and dout_id = 0, gnt low from the done cycle.
- Contention: req = 11 held for 3 conversions → grant order 0, 1, 0, with dout_id sequence 0, 1, 0.
- Stale INTR: model holds intr_n low across wr_n and releases it high 5 cycles into WAIT, then low 20 cycles later → READ entered only after the second low. Exactly one done.
- Timeout: model never asserts intr_n → done and timeout_err both pulse 64 cycles after WAIT entry, dout keeps its prior value, and the next request is granted to the other requester.
- Request withdrawn: req[1] drops during WAIT → conversion completes and done is issued with dout_id = 1.
- Reset mid-READ: rst pulse while rd_n = 0 → cs_n = wr_n = rd_n = 1 and gnt = 0 asynchronously, with no done pulse; after release, the first grant goes to requester 0.

Source files
------------

// File: rtl/adc_sched_pkg.sv
// Shared types and defaults for the ADC0804 round-robin conversion scheduler.
// Combinational helpers only; no state and no flow control.
package adc_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        READ  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam int DEF_N_REQ    = 2;
    localparam int DEF_WR_CYC   = 4;
    localparam int DEF_RD_CYC   = 4;
    localparam int DEF_TIMEOUT  = 10000;
    localparam int DEF_IDLE_GAP = 10;

    // Requester index width; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req bit searching upward from last+1 with wrap.
// Purely combinational; gnt stays zero while en is low.
module rr_arbiter
    import adc_sched_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic found;
    int   pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 1; k <= N; k++) begin
            pos = (int'(last) + k) % N;
            if (en && !found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/adc0804_rr_sched.sv
// Single owner of the ADC0804 pins: round-robin grant, START/WAIT/READ strobe sequencing, ID-tagged results.
// Requests are levels held until done; a conversion never aborts except on rst or WAIT timeout.
module adc0804_rr_sched
    import adc_sched_pkg::*;
#(
    parameter  int N_REQ    = DEF_N_REQ,
    parameter  int WR_CYC   = DEF_WR_CYC,
    parameter  int RD_CYC   = DEF_RD_CYC,
    parameter  int TIMEOUT  = DEF_TIMEOUT,
    parameter  int IDLE_GAP = DEF_IDLE_GAP,
    localparam int IDW      = id_w(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic             done,
    output logic [7:0]       dout,
    output logic [IDW-1:0]   dout_id,
    output logic             timeout_err,
    output logic             cs_n,
    output logic             wr_n,
    output logic             rd_n,
    input  logic             intr_n,
    input  logic [7:0]       adata
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(max3(WR_CYC, RD_CYC, IDLE_GAP) + 1);

    localparam logic [CW-1:0] WR_LAST  = CW'(WR_CYC - 1);
    localparam logic [CW-1:0] RD_LAST  = CW'(RD_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(IDLE_GAP - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [TW-1:0]    wcnt;
    logic             armed;
    logic [IDW-1:0]   last;
    logic [IDW-1:0]   gidx;
    logic             intr_m;
    logic             intr_s;
    logic [N_REQ-1:0] arb_gnt;
    logic [IDW-1:0]   arb_idx;

    // intr_n is asynchronous to clk; idle level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            intr_m <= 1'b1;
            intr_s <= 1'b1;
        end else begin
            intr_m <= intr_n;
            intr_s <= intr_m;
        end
    end

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req  (req),
        .last (last),
        .en   (state == IDLE),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            wcnt        <= '0;
            armed       <= 1'b0;
            last        <= IDW'(N_REQ - 1);
            gidx        <= '0;
            gnt         <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            dout        <= '0;
            dout_id     <= '0;
            cs_n        <= 1'b1;
            wr_n        <= 1'b1;
            rd_n        <= 1'b1;
        end else begin
            done        <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= START;
                        gnt   <= arb_gnt;
                        gidx  <= arb_idx;
                        cs_n  <= 1'b0;
                        wr_n  <= 1'b0;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == WR_LAST) begin
                        state <= WAIT;
                        cs_n  <= 1'b1;
                        wr_n  <= 1'b1;
                        wcnt  <= '0;
                        armed <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    // Only a high-then-low INTR counts, so a low left from the last read is ignored.
                    if (armed && !intr_s) begin
                        state <= READ;
                        cs_n  <= 1'b0;
                        rd_n  <= 1'b0;
                        cnt   <= '0;
                    end else if (wcnt == TO_LAST) begin
                        state       <= GAP;
                        done        <= 1'b1;
                        timeout_err <= 1'b1;
                        dout_id     <= gidx;
                        gnt         <= '0;
                        last        <= gidx;
                        cnt         <= '0;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                        if (intr_s) begin
                            armed <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (cnt == RD_LAST) begin
                        state   <= GAP;
                        dout    <= adata;
                        done    <= 1'b1;
                        dout_id <= gidx;
                        gnt     <= '0;
                        last    <= gidx;
                        cs_n    <= 1'b1;
                        rd_n    <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc0804_rr_sched.sv
// Directed + randomized bench for adc0804_rr_sched with a behavioural ADC0804 and round-robin reference model.
module tb_adc0804_rr_sched;

    localparam int N       = 2;
    localparam int TIMEOUT = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         busy, done, timeout_err;
    logic [7:0]   dout;
    logic [0:0]   dout_id;
    logic         cs_n, wr_n, rd_n;
    logic         intr_n;
    logic [7:0]   adata;

    always #5 clk = ~clk;

    adc0804_rr_sched #(
        .N_REQ    (N),
        .WR_CYC   (4),
        .RD_CYC   (4),
        .TIMEOUT  (TIMEOUT),
        .IDLE_GAP (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .gnt         (gnt),
        .busy        (busy),
        .done        (done),
        .dout        (dout),
        .dout_id     (dout_id),
        .timeout_err (timeout_err),
        .cs_n        (cs_n),
        .wr_n        (wr_n),
        .rd_n        (rd_n),
        .intr_n      (intr_n),
        .adata       (adata)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe/grant monitor, sampled 2 time units after each rising edge.
    int   cyc = 0;
    int   onehot_bad = 0;
    int   done_cnt = 0, done_cyc = 0;
    int   wr_len = 0, wr_last_len = 0, wr_fall_cyc = 0, wait_entry_cyc = 0;
    int   rd_len = 0, rd_last_len = 0, rd_fall_cyc = 0;
    logic prev_wr = 1'b1, prev_rd = 1'b1;

    always @(posedge clk) begin
        #2;
        cyc++;
        if (!$onehot0(gnt)) onehot_bad++;
        if (!wr_n) begin
            if (prev_wr) begin wr_fall_cyc = cyc; wr_len = 1; end
            else wr_len++;
        end else if (!prev_wr) begin
            wr_last_len    = wr_len;
            wait_entry_cyc = cyc;
        end
        if (!rd_n) begin
            if (prev_rd) begin rd_fall_cyc = cyc; rd_len = 1; end
            else rd_len++;
        end else if (!prev_rd) begin
            rd_last_len = rd_len;
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        prev_wr = wr_n;
        prev_rd = rd_n;
    end

    // ADC0804 model. mode 0: INTR low 20 cycles after wr_n rises; 1: stale low
    // released 5 cycles into WAIT then low 20 cycles later; 2: INTR never asserts.
    int   mode = 0;
    int   cd_hi = 0, cd_lo = 0;
    int   intr_lo_cyc = 0;
    logic mwr_prev = 1'b1;

    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (mode == 2) begin
                intr_n = 1'b1;
            end else begin
                if (!rd_n) intr_n = 1'b1;
                if (!wr_n && mode == 0) intr_n = 1'b1;
                if (wr_n && !mwr_prev) begin
                    if (mode == 0) cd_lo = 20;
                    else begin cd_hi = 5; cd_lo = 25; end
                end
                if (cd_hi > 0) begin
                    cd_hi--;
                    if (cd_hi == 0) intr_n = 1'b1;
                end
                if (cd_lo > 0) begin
                    cd_lo--;
                    if (cd_lo == 0) begin intr_n = 1'b0; intr_lo_cyc = cyc; end
                end
            end
            mwr_prev = wr_n;
        end
    end

    // Reference model: rotating pointer plus the last delivered sample.
    int         ptr = N - 1;
    logic [7:0] last_dout = 8'h00;

    function automatic int pick(input int p, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic do_conv(input string tag, input logic [N-1:0] r, input logic [7:0] val,
                           input bit exp_to, input bit drop, input bit hold);
        bit         ok;
        int         e;
        logic [7:0] exp_dout;
        wait_idle(ok);
        chk({tag, "_idle"}, 32'(ok), 1);
        adata = val;
        req   = r;
        e     = pick(ptr, r);
        @(negedge clk);
        chk({tag, "_wr_low"}, 32'(wr_n), 0);
        chk({tag, "_gnt"}, 32'(gnt), 32'(1) << e);
        if (drop) begin
            for (int i = 0; i < 20 && !wr_n; i++) @(negedge clk);
            req = '0;
        end
        wait_done(TIMEOUT + 200, ok);
        chk({tag, "_done"}, 32'(ok), 1);
        exp_dout = exp_to ? last_dout : val;
        chk({tag, "_dout"}, 32'(dout), 32'(exp_dout));
        chk({tag, "_id"}, 32'(dout_id), 32'(e));
        chk({tag, "_to_err"}, 32'(timeout_err), 32'(exp_to));
        chk({tag, "_gnt_off"}, 32'(gnt), 0);
        if (!exp_to) last_dout = val;
        ptr = e;
        if (!hold) req = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         d, dc0, dsave;
        bit         ok;
        logic [N-1:0] r;
        logic [7:0] v;

        rst = 1'b1; req = '0; intr_n = 1'b1; adata = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cs_n", 32'(cs_n), 1);
        chk("rst_wr_n", 32'(wr_n), 1);
        chk("rst_rd_n", 32'(rd_n), 1);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_to_err", 32'(timeout_err), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_dout_id", 32'(dout_id), 0);
        rst = 1'b0;

        // All requesters high: rotation 0,1,0.
        do_conv("cont0", 2'b11, 8'h11, 1'b0, 1'b0, 1'b1);
        do_conv("cont1", 2'b11, 8'h22, 1'b0, 1'b0, 1'b1);
        do_conv("cont2", 2'b11, 8'h33, 1'b0, 1'b0, 1'b0);

        // Single conversion: strobe widths and INTR-to-READ latency.
        do_conv("single", 2'b01, 8'hA5, 1'b0, 1'b0, 1'b1);
        chk("single_wr_len", 32'(wr_last_len), 4);
        chk("single_rd_len", 32'(rd_last_len), 4);
        d = rd_fall_cyc - intr_lo_cyc;
        chk("single_intr_lat", 32'(d == 3 || d == 4), 1);

        // Same requester held: next START is IDLE_GAP+1 cycles after done.
        dsave = done_cyc;
        do_conv("b2b", 2'b01, 8'h5A, 1'b0, 1'b0, 1'b0);
        chk("b2b_spacing", 32'(wr_fall_cyc - dsave), 11);

        // Stale INTR low across the start strobe.
        mode = 1; intr_n = 1'b0;
        dc0 = done_cnt;
        do_conv("stale", 2'b10, 8'h3C, 1'b0, 1'b0, 1'b0);
        d = rd_fall_cyc - intr_lo_cyc;
        chk("stale_intr_lat", 32'(d == 3 || d == 4), 1);
        repeat (20) @(negedge clk);
        chk("stale_one_done", 32'(done_cnt - dc0), 1);
        mode = 0;

        // Timeout: INTR never arrives.
        mode = 2;
        do_conv("tmo", 2'b01, 8'hEE, 1'b1, 1'b0, 1'b0);
        chk("tmo_latency", 32'(done_cyc - wait_entry_cyc), 64);
        mode = 0;
        do_conv("tmo_next", 2'b11, 8'h77, 1'b0, 1'b0, 1'b0);

        // Requester withdraws during WAIT; result still returned with its ID.
        do_conv("withdraw", 2'b10, 8'h96, 1'b0, 1'b1, 1'b0);

        // Leave pointer at 0, then reset in the middle of READ for requester 1.
        do_conv("pre_rst", 2'b01, 8'h42, 1'b0, 1'b0, 1'b0);
        wait_idle(ok);
        req = 2'b10; adata = 8'hC3;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!rd_n) begin ok = 1'b1; break; end
        end
        chk("rst_mid_reached_read", 32'(ok), 1);
        dc0 = done_cnt;
        rst = 1'b1;
        #1;
        chk("rst_mid_cs_n", 32'(cs_n), 1);
        chk("rst_mid_wr_n", 32'(wr_n), 1);
        chk("rst_mid_rd_n", 32'(rd_n), 1);
        chk("rst_mid_gnt", 32'(gnt), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_dout", 32'(dout), 0);
        req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ptr = N - 1;
        last_dout = 8'h00;
        repeat (20) @(negedge clk);
        chk("rst_mid_no_done", 32'(done_cnt - dc0), 0);
        do_conv("post_rst", 2'b11, 8'h81, 1'b0, 1'b0, 1'b0);

        // Randomized request patterns and sample values.
        for (int it = 0; it < 8; it++) begin
            r = N'($urandom_range(1, 3));
            v = 8'($urandom);
            do_conv($sformatf("rnd%0d", it), r, v, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        end
        req = '0;

        chk("gnt_onehot_violations", 32'(onehot_bad), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
